// File: rtl/exec_pkg.sv
// exec_pkg: ALU op codes, operand-select codes and FSM states shared by the execute stage
package exec_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_SEXT = 2'b01;
  localparam logic [1:0] SRC_UIMM = 2'b10;
  typedef enum logic {S_IDLE, S_MUL} state_t;
endpackage

// File: rtl/iter_multiplier.sv
// iter_multiplier: shift-add multiplier, one step per cycle, XLEN steps after start
module iter_multiplier #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int CW = $clog2(XLEN) + 1;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand, mplier, acc;
  // product already includes the step being taken this cycle, so the final
  // step and the result write share one edge; once mplier is exhausted it equals acc
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = cnt >= CW'(XLEN - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= CW'(XLEN);
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (cnt != CW'(XLEN)) begin
      cnt    <= cnt + 1'b1;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= product;
    end
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: handshaked LEGv8 execute stage with iterative MUL, branch resolution and a one-entry output buffer
module execute_stage
  import exec_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int UIMM_W = 12,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [3:0]        in_op,
  input  logic [1:0]        in_alusrc,
  input  logic [XLEN-1:0]   in_sext,
  input  logic [UIMM_W-1:0] in_uimm,
  input  logic [XLEN-1:0]   in_d1,
  input  logic [XLEN-1:0]   in_d2,
  input  logic [4:0]        in_rd,
  input  logic              in_b,
  input  logic              in_bz,
  input  logic              in_bnz,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic              out_zero,
  output logic [XLEN-1:0]   out_target,
  output logic              out_pcsrc,
  output logic [XLEN-1:0]   out_store,
  output logic [4:0]        out_rd,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_memtoreg,
  output logic              out_regwrite,
  output logic              out_illegal
);
  state_t state, state_nxt;
  logic live, op_ok, ill, is_mul, accept, start, drain_ok, mul_done, wr, m;
  logic [XLEN-1:0] opb, alu_res, prod, res, pc_s, sext_s, d2_s;
  logic [XLEN-1:0] h_pc, h_sext, h_d2;
  logic [4:0] h_rd, rd_s;
  logic h_b, h_bz, h_bnz, h_memread, h_memwrite, h_memtoreg, h_regwrite;
  logic b_s, bz_s, bnz_s, memread_s, memwrite_s, memtoreg_s, regwrite_s, zero, ill_s, pcsrc;
  assign opb = in_alusrc == SRC_REG  ? in_d2 :
               in_alusrc == SRC_SEXT ? in_sext : XLEN'(in_uimm);
  always_comb begin
    alu_res = '0;
    op_ok   = 1'b1;
    case (in_op)
      OP_AND:  alu_res = in_d1 & opb;
      OP_OR:   alu_res = in_d1 | opb;
      OP_ADD:  alu_res = in_d1 + opb;
      OP_SUB:  alu_res = in_d1 - opb;
      OP_PASS: alu_res = opb;
      OP_NOR:  alu_res = ~(in_d1 | opb);
      OP_MUL:  op_ok   = MUL_EN;
      default: op_ok   = 1'b0;
    endcase
  end
  assign ill      = ~op_ok | (in_alusrc == 2'b11);
  assign is_mul   = (in_op == OP_MUL) & ~ill;
  assign drain_ok = ~out_valid | out_ready;
  // live holds in_ready low for the first cycle after reset release
  assign in_ready = live & (state == S_IDLE) & drain_ok & ~flush;
  assign accept   = in_valid & in_ready;
  assign start    = accept & is_mul;
  assign m        = state == S_MUL;
  assign wr       = (accept & ~is_mul) | (m & mul_done & drain_ok & ~flush);
  iter_multiplier #(.XLEN(XLEN)) u_mul (
    .clk(clk), .rst_n(rst_n), .start(start), .a(in_d1), .b(opb),
    .done(mul_done), .product(prod)
  );
  // in MUL the buffer is written from the held fields, otherwise straight from the inputs
  assign res        = m ? prod : (ill ? '0 : alu_res);
  assign pc_s       = m ? h_pc : in_pc;
  assign sext_s     = m ? h_sext : in_sext;
  assign d2_s       = m ? h_d2 : in_d2;
  assign rd_s       = m ? h_rd : in_rd;
  assign b_s        = m ? h_b : in_b;
  assign bz_s       = m ? h_bz : in_bz;
  assign bnz_s      = m ? h_bnz : in_bnz;
  assign memread_s  = m ? h_memread : in_memread;
  assign memwrite_s = m ? h_memwrite : in_memwrite;
  assign memtoreg_s = m ? h_memtoreg : in_memtoreg;
  assign regwrite_s = m ? h_regwrite : in_regwrite;
  assign ill_s      = ~m & ill;
  assign zero       = res == '0;
  assign pcsrc      = ~ill_s & (b_s | (bz_s & zero) | (bnz_s & ~zero));
  always_comb begin
    state_nxt = state;
    if (state == S_IDLE) state_nxt = start ? S_MUL : S_IDLE;
    else if (flush | (mul_done & drain_ok)) state_nxt = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {h_pc, h_sext, h_d2, h_rd} <= '0;
      {h_b, h_bz, h_bnz, h_memread, h_memwrite, h_memtoreg, h_regwrite} <= '0;
    end else if (start) begin
      {h_pc, h_sext, h_d2, h_rd} <= {in_pc, in_sext, in_d2, in_rd};
      {h_b, h_bz, h_bnz, h_memread, h_memwrite, h_memtoreg, h_regwrite} <=
        {in_b, in_bz, in_bnz, in_memread, in_memwrite, in_memtoreg, in_regwrite};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      {out_result, out_zero, out_target, out_pcsrc, out_store, out_rd} <= '0;
      {out_memread, out_memwrite, out_memtoreg, out_regwrite, out_illegal} <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (wr) begin
      out_valid    <= 1'b1;
      out_result   <= res;
      out_zero     <= zero;
      out_target   <= pc_s + (sext_s << 2);
      out_pcsrc    <= pcsrc;
      out_store    <= d2_s;
      out_rd       <= rd_s;
      out_memread  <= memread_s & ~ill_s;
      out_memwrite <= memwrite_s & ~ill_s;
      out_memtoreg <= memtoreg_s;
      out_regwrite <= regwrite_s & ~ill_s;
      out_illegal  <= ill_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage
module tb_execute_stage;
  localparam int XLEN = 64;
  logic clk = 1'b0, rst_n, flush, in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_sext, in_d1, in_d2;
  logic [3:0] in_op;
  logic [1:0] in_alusrc;
  logic [11:0] in_uimm;
  logic [4:0] in_rd, out_rd;
  logic in_b, in_bz, in_bnz, in_memread, in_memwrite, in_memtoreg, in_regwrite;
  logic out_valid, out_ready, out_zero, out_pcsrc;
  logic [XLEN-1:0] out_result, out_target, out_store;
  logic out_memread, out_memwrite, out_memtoreg, out_regwrite, out_illegal;
  int checks = 0, errors = 0;
  execute_stage #(.XLEN(XLEN), .UIMM_W(12), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_op(in_op), .in_alusrc(in_alusrc), .in_sext(in_sext), .in_uimm(in_uimm),
    .in_d1(in_d1), .in_d2(in_d2), .in_rd(in_rd), .in_b(in_b), .in_bz(in_bz), .in_bnz(in_bnz),
    .in_memread(in_memread), .in_memwrite(in_memwrite), .in_memtoreg(in_memtoreg),
    .in_regwrite(in_regwrite), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_target(out_target), .out_pcsrc(out_pcsrc),
    .out_store(out_store), .out_rd(out_rd), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_memtoreg(out_memtoreg), .out_regwrite(out_regwrite), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [3:0] o, input logic [1:0] src, input logic [XLEN-1:0] d1,
                    input logic [XLEN-1:0] d2, input logic [XLEN-1:0] sext, input logic [11:0] uimm);
    in_op = o; in_alusrc = src; in_d1 = d1; in_d2 = d2; in_sext = sext; in_uimm = uimm;
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_rd = '0; op(4'h0, 2'b00, '0, '0, '0, '0);
    {in_b, in_bz, in_bnz, in_memread, in_memwrite, in_memtoreg, in_regwrite} = '0;
    repeat (2) tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_target", out_target, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick;
    chk("post_rst_in_ready", in_ready, 1);
    // ADD 5+7
    in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd3;
    op(4'b0010, 2'b00, 64'd5, 64'd7, '0, '0);
    tick;
    chk("add_result", out_result, 64'd12);
    chk("add_zero", out_zero, 0);
    chk("add_valid", out_valid, 1);
    chk("add_regwrite", out_regwrite, 1);
    chk("add_rd", out_rd, 5'd3);
    chk("add_store", out_store, 64'd7);
    // SUB 9-9 with CBZ, accepted while previous result drains
    in_regwrite = 1'b0; in_bz = 1'b1; in_pc = 64'h100;
    op(4'b0110, 2'b00, 64'd9, 64'd9, 64'd4, '0);
    tick;
    chk("sub_result", out_result, 0);
    chk("sub_zero", out_zero, 1);
    chk("sub_pcsrc", out_pcsrc, 1);
    chk("sub_target", out_target, 64'h110);
    chk("sub_illegal", out_illegal, 0);
    // MUL 3 * -1
    in_bz = 1'b0; in_pc = '0; in_rd = 5'd7;
    op(4'b1000, 2'b00, 64'd3, '1, '0, '0);
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= XLEN; k++) begin
      chk("mul_busy_in_ready", in_ready, 0);
      chk("mul_busy_valid", out_valid, 0);
      tick;
    end
    chk("mul_valid", out_valid, 1);
    chk("mul_result", out_result, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("mul_rd", out_rd, 5'd7);
    chk("mul_in_ready", in_ready, 1);
    // ORR then back-pressure
    in_valid = 1'b1; in_rd = 5'd5;
    op(4'b0001, 2'b00, 64'hF0, 64'h0F, '0, '0);
    tick;
    chk("orr_result", out_result, 64'hFF);
    out_ready = 1'b0; in_rd = 5'd9;
    op(4'b0010, 2'b10, 64'd1, 64'd50, '0, 12'd2);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", in_ready, 0);
      tick;
      chk("bp_valid", out_valid, 1);
      chk("bp_result", out_result, 64'hFF);
      chk("bp_rd", out_rd, 5'd5);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    tick;
    chk("bp_next_result", out_result, 64'd3);
    chk("bp_next_rd", out_rd, 5'd9);
    in_valid = 1'b0;
    tick;
    chk("drained_valid", out_valid, 0);
    // MUL aborted by flush at step 10; same-cycle in_valid discarded
    in_valid = 1'b1;
    op(4'b1000, 2'b00, 64'd6, 64'd7, '0, '0);
    tick;
    in_valid = 1'b0;
    repeat (10) tick;
    flush = 1'b1; in_valid = 1'b1;
    op(4'b0010, 2'b00, 64'd1, 64'd1, '0, '0);
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_idle_in_ready", in_ready, 1);
    for (int k = 0; k < 70; k++) begin
      tick;
      chk("flush_no_residual", out_valid, 0);
    end
    in_valid = 1'b1;
    op(4'b0010, 2'b01, 64'd100, '0, '1, '0);
    tick;
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_result", out_result, 64'd99);
    // NOR and PASS of zero-extended uimm
    op(4'b1100, 2'b00, '0, '0, '0, '0);
    tick;
    chk("nor_result", out_result, '1);
    chk("nor_zero", out_zero, 0);
    op(4'b0111, 2'b10, 64'd5, '0, '0, 12'hFFF);
    tick;
    chk("pass_uimm", out_result, 64'hFFF);
    // illegal op code
    in_regwrite = 1'b1; in_memwrite = 1'b1; in_memread = 1'b1; in_b = 1'b1;
    op(4'b0101, 2'b00, 64'd3, 64'd4, '0, '0);
    tick;
    chk("ill_op_flag", out_illegal, 1);
    chk("ill_op_result", out_result, 0);
    chk("ill_op_regwrite", out_regwrite, 0);
    chk("ill_op_memwrite", out_memwrite, 0);
    chk("ill_op_memread", out_memread, 0);
    chk("ill_op_pcsrc", out_pcsrc, 0);
    // illegal alusrc
    op(4'b0010, 2'b11, 64'd3, 64'd4, '0, '0);
    tick;
    chk("ill_src_flag", out_illegal, 1);
    chk("ill_src_result", out_result, 0);
    chk("ill_src_regwrite", out_regwrite, 0);
    chk("ill_src_memwrite", out_memwrite, 0);
    chk("ill_src_pcsrc", out_pcsrc, 0);
    // unconditional branch on a legal op
    op(4'b0010, 2'b00, 64'd1, 64'd1, 64'd3, '0);
    in_memwrite = 1'b0; in_memread = 1'b0; in_pc = 64'h40;
    tick;
    chk("b_pcsrc", out_pcsrc, 1);
    chk("b_target", out_target, 64'h4C);
    chk("b_regwrite", out_regwrite, 1);
    in_valid = 1'b0;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
